// File: rtl/b16_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : b16_rom_arbiter
// Brief    : Two-port round-robin arbiter and read sequencer for the B16 boot ROM.
// Revision : 1.0 - initial release
// ============================================================================
module b16_rom_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16,
  parameter int ROM_BYTES = 4096,
  parameter int ROM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  output logic              rom_strobe,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_oe,
  output logic [1:0]        rom_byte_en,
  input  logic [DATA_W-1:0] rom_rddata,
  output logic              busy
);

  localparam int                CNT_W       = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [ADDR_W:0]   c_rom_bytes = (ADDR_W+1)'(ROM_BYTES);
  localparam logic [CNT_W-1:0]  c_cnt_init  = CNT_W'(ROM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_last, w_last_nxt;
  logic               r_owner, w_owner_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_strobe, w_strobe_nxt;
  logic               r_oe, w_oe_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic [DATA_W-1:0]  r_data, w_data_nxt;
  logic               r_err, w_err_nxt;

  logic               w_grant0, w_grant1, w_hs, w_sel, w_in_range, w_rsp_hs;
  logic [ADDR_W-1:0]  w_req_addr;

  // On a tie the port that did not win last time gets the grant.
  assign w_grant0   = req0_valid & (~req1_valid | r_last);
  assign w_grant1   = req1_valid & (~req0_valid | ~r_last);
  assign req0_ready = (r_state == S_IDLE) & w_grant0;
  assign req1_ready = (r_state == S_IDLE) & w_grant1;
  assign w_hs       = req0_ready | req1_ready;
  assign w_sel      = req1_ready;
  assign w_req_addr = w_sel ? req1_addr : req0_addr;
  assign w_in_range = {1'b0, w_req_addr} < c_rom_bytes;
  assign w_rsp_hs   = (r_state == S_RESP) & (r_owner ? rsp1_ready : rsp0_ready);

  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_owner_nxt  = r_owner;
    w_cnt_nxt    = r_cnt;
    w_strobe_nxt = 1'b0;
    w_oe_nxt     = 1'b0;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_err_nxt    = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_last_nxt  = w_sel;
          w_owner_nxt = w_sel;
          if (w_in_range) begin
            w_state_nxt  = S_ACCESS;
            w_strobe_nxt = 1'b1;
            w_addr_nxt   = {w_req_addr[ADDR_W-1:1], 1'b0};
            w_err_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_RESP;
            w_data_nxt  = '0;
            w_err_nxt   = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = c_cnt_init;
        w_oe_nxt    = (c_cnt_init == '0);
      end
      S_WAIT: begin
        // OE is registered, so it is raised one cycle ahead of the capture cycle.
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          w_oe_nxt  = (r_cnt == CNT_W'(1));
        end else begin
          w_data_nxt  = rom_rddata;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rsp_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_oe     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_owner  <= w_owner_nxt;
      r_cnt    <= w_cnt_nxt;
      r_strobe <= w_strobe_nxt;
      r_oe     <= w_oe_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign rsp0_valid  = (r_state == S_RESP) & ~r_owner;
  assign rsp1_valid  = (r_state == S_RESP) & r_owner;
  assign rsp0_data   = r_data;
  assign rsp1_data   = r_data;
  assign rsp0_err    = r_err;
  assign rsp1_err    = r_err;
  assign rom_strobe  = r_strobe;
  assign rom_addr    = r_addr;
  assign rom_oe      = r_oe;
  assign rom_byte_en = 2'b11;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_b16_rom_arbiter.sv
`default_nettype none
// Bench for b16_rom_arbiter: ROM_LAT=1 instance exercised per feature plus
// randomized traffic, and a ROM_LAT=3 instance for latency/OE timing.
module tb_b16_rom_arbiter;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic        rom_strobe, rom_oe, busy;
  logic [15:0] rsp0_data, rsp1_data, rom_rddata;
  logic [31:0] rom_addr;
  logic [1:0]  rom_byte_en;

  logic        d3_req_valid = 1'b0, d3_rsp_ready = 1'b0;
  logic [31:0] d3_req_addr = '0;
  logic        d3_req0_ready, d3_req1_ready, d3_rsp0_valid, d3_rsp1_valid, d3_rsp0_err, d3_rsp1_err;
  logic        d3_strobe, d3_oe, d3_busy;
  logic [15:0] d3_rsp0_data, d3_rsp1_data, d3_rddata;
  logic [31:0] d3_addr;
  logic [1:0]  d3_byte_en;

  int total = 0;
  int bad   = 0;
  int m_last = 1;
  logic [15:0] mem [2048];

  b16_rom_arbiter #(.ADDR_W(32), .DATA_W(16), .ROM_BYTES(4096), .ROM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .rom_strobe(rom_strobe), .rom_addr(rom_addr), .rom_oe(rom_oe), .rom_byte_en(rom_byte_en),
    .rom_rddata(rom_rddata), .busy(busy));

  b16_rom_arbiter #(.ADDR_W(32), .DATA_W(16), .ROM_BYTES(4096), .ROM_LAT(LAT3)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(d3_req_valid), .req0_ready(d3_req0_ready), .req0_addr(d3_req_addr),
    .rsp0_valid(d3_rsp0_valid), .rsp0_ready(d3_rsp_ready), .rsp0_data(d3_rsp0_data), .rsp0_err(d3_rsp0_err),
    .req1_valid(1'b0), .req1_ready(d3_req1_ready), .req1_addr(32'h0),
    .rsp1_valid(d3_rsp1_valid), .rsp1_ready(1'b0), .rsp1_data(d3_rsp1_data), .rsp1_err(d3_rsp1_err),
    .rom_strobe(d3_strobe), .rom_addr(d3_addr), .rom_oe(d3_oe), .rom_byte_en(d3_byte_en),
    .rom_rddata(d3_rddata), .busy(d3_busy));

  // Behavioural ROM: word is fetched on the strobe edge and becomes valid LAT clocks later.
  logic [15:0] wq1 = '0, wq3 = '0;
  int age1 = 0, age3 = 0;
  always @(posedge clk) begin
    if (rom_strobe) begin wq1 <= mem[rom_addr[11:1]]; age1 <= 1; end
    else if (age1 < 1000) age1 <= age1 + 1;
    if (d3_strobe) begin wq3 <= mem[d3_addr[11:1]]; age3 <= 1; end
    else if (age3 < 1000) age3 <= age3 + 1;
  end
  assign rom_rddata = !rom_oe ? 16'h0000 : ((age1 >= LAT)  ? wq1 : 16'hDEAD);
  assign d3_rddata  = !d3_oe  ? 16'h0000 : ((age3 >= LAT3) ? wq3 : 16'hDEAD);

  function automatic logic [15:0] exp_data(input logic [31:0] a);
    return (a >= 32'd4096) ? 16'h0000 : mem[a[11:1]];
  endfunction

  function automatic int exp_grant(input logic v0, input logic v1);
    if (v0 && v1) return (m_last == 0) ? 1 : 0;
    return v0 ? 0 : 1;
  endfunction

  // viol bits: 0 both req_ready, 1 wrong-port rsp, 2 busy low, 3 req_ready while busy,
  // 4 rsp changed under backpressure, 5 still valid/busy after accept
  task automatic run_txn(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] a1,
                         input int stall, input logic keep0,
                         output int g, output int lat, output int stb_cyc, output int nstb, output int noe,
                         output logic [15:0] data, output logic err, output logic [5:0] viol);
    int k;
    g = -1; lat = -1; stb_cyc = -1; nstb = 0; noe = 0; data = '0; err = 1'b0; viol = '0; k = 0;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1; req0_addr = a0; req1_addr = a1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    while (!req0_ready && !req1_ready && k < 20) begin @(negedge clk); k++; end
    if (!req0_ready && !req1_ready) begin req0_valid = 1'b0; req1_valid = 1'b0; return; end
    if (req0_ready && req1_ready) viol[0] = 1'b1;
    g = req0_ready ? 0 : 1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (rom_strobe) begin nstb++; if (stb_cyc < 0) stb_cyc = c; end
      if (rom_oe) noe++;
      if ((g == 0) ? rsp1_valid : rsp0_valid) viol[1] = 1'b1;
      if (!busy) viol[2] = 1'b1;
      if (req0_ready || req1_ready) viol[3] = 1'b1;
      if ((g == 0) ? rsp0_valid : rsp1_valid) begin
        lat  = c;
        data = (g == 0) ? rsp0_data : rsp1_data;
        err  = (g == 0) ? rsp0_err : rsp1_err;
      end
      if (c == 1) begin req0_valid = keep0; req1_valid = 1'b0; end
    end
    if (lat > 0) begin
      if (g == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (!((g == 0) ? rsp0_valid : rsp1_valid)) viol[4] = 1'b1;
        if (((g == 0) ? rsp0_data : rsp1_data) !== data) viol[4] = 1'b1;
        if (((g == 0) ? rsp0_err : rsp1_err) !== err) viol[4] = 1'b1;
        if ((g == 0) ? rsp1_valid : rsp0_valid) viol[1] = 1'b1;
        if (!busy) viol[2] = 1'b1;
        if (req0_ready || req1_ready) viol[3] = 1'b1;
      end
      if (g == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      req0_valid = 1'b0;
      @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      if (rsp0_valid || rsp1_valid || busy) viol[5] = 1'b1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({busy, rom_strobe, rom_oe, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 7'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0000000", {busy, rom_strobe, rom_oe, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}); end
    total++; if (rom_addr !== 32'h0) begin bad++; $display("FAIL reset_rom_addr got=%h want=0", rom_addr); end
    total++; if (rsp0_data !== 16'h0 || rsp1_data !== 16'h0) begin
      bad++; $display("FAIL reset_rsp_data got=%h/%h want=0000", rsp0_data, rsp1_data); end
    total++; if (rom_byte_en !== 2'b11) begin bad++; $display("FAIL reset_byte_en got=%b want=11", rom_byte_en); end
    rst = 1'b0;
    m_last = 1;
  endtask

  task automatic test_single();
    int g, lat, sc, ns, no; logic [15:0] d; logic e; logic [5:0] v;
    run_txn(1'b1, 1'b0, 32'h4, 32'h0, 0, 1'b0, g, lat, sc, ns, no, d, e, v);
    total++; if (g !== 0) begin bad++; $display("FAIL single_grant got=%0d want=0", g); end
    total++; if (sc !== 1 || ns !== 1) begin bad++; $display("FAIL single_strobe cyc=%0d n=%0d want cyc=1 n=1", sc, ns); end
    total++; if (lat !== 2 + LAT) begin bad++; $display("FAIL single_latency got=%0d want=%0d", lat, 2 + LAT); end
    total++; if (d !== 16'hBEEF || e !== 1'b0) begin bad++; $display("FAIL single_data got=%h err=%b want=beef err=0", d, e); end
    total++; if (no !== 1 || v !== 6'b0) begin bad++; $display("FAIL single_protocol oe=%0d viol=%b want oe=1 viol=0", no, v); end
    m_last = 0;
  endtask

  task automatic test_contention();
    int g, lat, sc, ns, no, eg; logic [15:0] d; logic e; logic [5:0] v; logic [31:0] a0, a1;
    for (int i = 0; i < 4; i++) begin
      a0 = {$urandom_range(0, 2047), 1'b0};
      a1 = {$urandom_range(0, 2047), 1'b0};
      eg = exp_grant(1'b1, 1'b1);
      run_txn(1'b1, 1'b1, a0, a1, 0, 1'b0, g, lat, sc, ns, no, d, e, v);
      total++; if (g !== eg) begin bad++; $display("FAIL contention_grant[%0d] got=%0d want=%0d", i, g, eg); end
      total++; if (d !== exp_data(eg == 1 ? a1 : a0) || v !== 6'b0) begin
        bad++; $display("FAIL contention_rsp[%0d] data=%h viol=%b want data=%h viol=0", i, d, v, exp_data(eg == 1 ? a1 : a0)); end
      m_last = eg;
    end
  endtask

  task automatic test_backpressure();
    int g, lat, sc, ns, no; logic [15:0] d; logic e; logic [5:0] v; logic [31:0] a;
    a = 32'h7A2;
    run_txn(1'b0, 1'b1, 32'h0, a, 10, 1'b1, g, lat, sc, ns, no, d, e, v);
    total++; if (g !== 1 || lat !== 2 + LAT) begin bad++; $display("FAIL backpressure_grant g=%0d lat=%0d want g=1 lat=%0d", g, lat, 2 + LAT); end
    total++; if (d !== exp_data(a) || e !== 1'b0) begin bad++; $display("FAIL backpressure_data got=%h want=%h", d, exp_data(a)); end
    total++; if (v !== 6'b0) begin bad++; $display("FAIL backpressure_protocol viol=%b want=000000", v); end
    m_last = 1;
  endtask

  task automatic test_out_of_range();
    int g, lat, sc, ns, no; logic [15:0] d; logic e; logic [5:0] v;
    run_txn(1'b0, 1'b1, 32'h0, 32'h1000, 2, 1'b0, g, lat, sc, ns, no, d, e, v);
    total++; if (g !== 1 || lat !== 1) begin bad++; $display("FAIL oor_timing g=%0d lat=%0d want g=1 lat=1", g, lat); end
    total++; if (e !== 1'b1 || d !== 16'h0) begin bad++; $display("FAIL oor_rsp err=%b data=%h want err=1 data=0000", e, d); end
    total++; if (ns !== 0 || no !== 0 || v !== 6'b0) begin bad++; $display("FAIL oor_rom strobes=%0d oe=%0d viol=%b want 0/0/0", ns, no, v); end
    m_last = 1;
    run_txn(1'b0, 1'b1, 32'h0, 32'hFFE, 0, 1'b0, g, lat, sc, ns, no, d, e, v);
    total++; if (lat !== 2 + LAT || e !== 1'b0 || d !== mem[2047]) begin
      bad++; $display("FAIL last_word lat=%0d err=%b data=%h want lat=%0d err=0 data=%h", lat, e, d, 2 + LAT, mem[2047]); end
    m_last = 1;
  endtask

  task automatic test_random();
    int g, lat, sc, ns, no, eg, mode, r, st; logic [15:0] d; logic e; logic [5:0] v;
    logic v0, v1; logic [31:0] a0, a1, ea;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      v0 = (mode != 1); v1 = (mode != 0);
      r = $urandom_range(0, 9);
      a0 = (r == 0) ? 32'h1000 + $urandom_range(0, 32'hFFFF) : (r == 1) ? 32'hFFF : $urandom_range(0, 4095);
      r = $urandom_range(0, 9);
      a1 = (r == 0) ? 32'hFFFF_FFFE : (r == 1) ? 32'hFFE : $urandom_range(0, 4095);
      st = $urandom_range(0, 3);
      eg = exp_grant(v0, v1);
      ea = (eg == 1) ? a1 : a0;
      run_txn(v0, v1, a0, a1, st, 1'b0, g, lat, sc, ns, no, d, e, v);
      total++; if (g !== eg) begin bad++; $display("FAIL rand_grant[%0d] got=%0d want=%0d", i, g, eg); end
      total++; if (lat !== ((ea >= 32'd4096) ? 1 : 2 + LAT)) begin
        bad++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, (ea >= 32'd4096) ? 1 : 2 + LAT); end
      total++; if (d !== exp_data(ea) || e !== (ea >= 32'd4096)) begin
        bad++; $display("FAIL rand_rsp[%0d] data=%h err=%b want data=%h err=%b", i, d, e, exp_data(ea), ea >= 32'd4096); end
      total++; if (v !== 6'b0 || ns !== ((ea >= 32'd4096) ? 0 : 1)) begin
        bad++; $display("FAIL rand_protocol[%0d] viol=%b strobes=%0d", i, v, ns); end
      m_last = eg;
    end
  endtask

  task automatic test_reset_mid();
    int k, g, lat, sc, ns, no; logic [15:0] d; logic e; logic [5:0] v; logic seen;
    k = 0; seen = 1'b0;
    @(negedge clk); req0_valid = 1'b1; req0_addr = 32'h10; #1;
    while (!req0_ready && k < 20) begin @(negedge clk); k++; end
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b want=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({busy, rom_strobe, rom_oe, rsp0_valid, rsp1_valid, rsp0_err} !== 6'b0 || rom_addr !== 32'h0 || rsp0_data !== 16'h0) begin
      bad++; $display("FAIL rstmid_outputs flags=%b addr=%h data=%h want all 0",
                      {busy, rom_strobe, rom_oe, rsp0_valid, rsp1_valid, rsp0_err}, rom_addr, rsp0_data); end
    rst = 1'b0;
    m_last = 1;
    repeat (4) begin @(negedge clk); if (rsp0_valid || rsp1_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp got=%b want=0", seen); end
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, 0, 1'b0, g, lat, sc, ns, no, d, e, v);
    total++; if (g !== 0 || lat !== 2 + LAT || d !== mem[16] || v !== 6'b0) begin
      bad++; $display("FAIL rstmid_fresh g=%0d lat=%0d data=%h viol=%b want g=0 lat=%0d data=%h", g, lat, d, v, 2 + LAT, mem[16]); end
    m_last = 0;
  endtask

  task automatic test_lat3();
    int k, lat, no; logic [31:0] a; logic [15:0] d; logic e, other;
    for (int i = 0; i < 3; i++) begin
      a = {$urandom_range(0, 2047), 1'b0};
      k = 0; lat = -1; no = 0; d = '0; e = 1'b1; other = 1'b0;
      @(negedge clk); d3_req_valid = 1'b1; d3_req_addr = a; #1;
      while (!d3_req0_ready && k < 20) begin @(negedge clk); k++; end
      for (int c = 1; c <= 30 && lat < 0; c++) begin
        @(negedge clk);
        if (d3_oe) no++;
        if (d3_rsp1_valid) other = 1'b1;
        if (d3_rsp0_valid) begin lat = c; d = d3_rsp0_data; e = d3_rsp0_err; end
        if (c == 1) d3_req_valid = 1'b0;
      end
      d3_req_valid = 1'b0;
      total++; if (lat !== 2 + LAT3 || no !== 1 || other !== 1'b0) begin
        bad++; $display("FAIL lat3_timing[%0d] lat=%0d oe=%0d p1=%b want lat=%0d oe=1 p1=0", i, lat, no, other, 2 + LAT3); end
      total++; if (d !== mem[a[11:1]] || e !== 1'b0) begin
        bad++; $display("FAIL lat3_data[%0d] got=%h err=%b want=%h err=0", i, d, e, mem[a[11:1]]); end
      d3_rsp_ready = 1'b1;
      @(negedge clk); d3_rsp_ready = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    mem[2] = 16'hBEEF;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_out_of_range();
    test_random();
    test_reset_mid();
    test_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
